// File: rtl/write_amble_gen.sv
// DDR5 write DQS strobe generator: preamble, toggling data phase, postamble, interamble merging.
// Define WR_AMBLE_STATS_EN to add saturating interamble / seamless-burst event counters.
module write_amble_gen #(
    parameter int unsigned SER_W = 2,
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CYC_W = 3,
    parameter int unsigned GAP_W = 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PAT_W-1:0] cfg_pre_pattern_i,
    input  logic [CYC_W-1:0] cfg_pre_cyc_i,
    input  logic [PAT_W-1:0] cfg_post_pattern_i,
    input  logic [CYC_W-1:0] cfg_post_cyc_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [GAP_W-1:0] wr_gap_i,
    input  logic [LEN_W-1:0] wr_len_i,
    output logic [SER_W-1:0] dqs_bits_o,
    output logic             dqs_oe_o,
    output logic             data_phase_o,
    output logic             interamble_o,
    output logic             busy_o
`ifdef WR_AMBLE_STATS_EN
    ,
    output logic [15:0]      stat_inter_cnt_o,
    output logic [15:0]      stat_seamless_cnt_o
`endif
);

    localparam int unsigned MAX_CYC = PAT_W / SER_W;

    // Slot n (1-based, counting down) of an MSB-first pattern.
    function automatic logic [SER_W-1:0] amble_slot(logic [PAT_W-1:0] pat, int unsigned n);
        logic [SER_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < MAX_CYC; i++) begin
            if (n == i + 1) s = pat[i*SER_W +: SER_W];
        end
        return s;
    endfunction

    function automatic logic [SER_W-1:0] toggle_pat();
        logic [SER_W-1:0] p;
        for (int i = 0; i < SER_W; i++) p[i] = 1'(i % 2);
        return p;
    endfunction

    localparam logic [SER_W-1:0] DATA_PAT = toggle_pat();

    typedef enum logic [1:0] {StIdle, StGap, StData, StPost} state_e;

    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0] gap_tot_q, gap_tot_d;
    logic             from_data_q, from_data_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic [CYC_W-1:0] post_cnt_q, post_cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [GAP_W-1:0] pend_gap_q, pend_gap_d;
    logic [LEN_W-1:0] pend_len_q, pend_len_d;

    logic [SER_W-1:0] dqs_bits_d;
    logic             dqs_oe_d, data_phase_d, interamble_d, busy_d, wr_ready_d;

    logic [CYC_W-1:0] pre_eff, post_eff;
    logic             accept, has_next, nxt_from;
    logic [GAP_W-1:0] nxt_gap;
    logic [LEN_W-1:0] nxt_len, len_in;
    int unsigned      rem, elapsed;

    always_comb begin
        pre_eff  = cfg_pre_cyc_i;
        post_eff = cfg_post_cyc_i;
        if (32'(cfg_pre_cyc_i) > MAX_CYC) pre_eff = CYC_W'(MAX_CYC);
        if (32'(cfg_post_cyc_i) > MAX_CYC) post_eff = CYC_W'(MAX_CYC);
    end

    assign accept = wr_valid_i & wr_ready_o;
    assign len_in = (wr_len_i == '0) ? LEN_W'(1) : wr_len_i;

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        gap_tot_d    = gap_tot_q;
        from_data_d  = from_data_q;
        len_cnt_d    = len_cnt_q;
        post_cnt_d   = post_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_gap_d   = pend_gap_q;
        pend_len_d   = pend_len_q;
        has_next     = 1'b0;
        nxt_from     = 1'b0;
        nxt_gap      = wr_gap_i;
        nxt_len      = len_in;

        case (state_q)
            StIdle: begin
                if (accept) has_next = 1'b1;
            end
            StPost: begin
                // A new request abandons the rest of the postamble.
                if (accept) begin
                    has_next = 1'b1;
                end else if (post_cnt_q <= CYC_W'(1)) begin
                    state_d = StIdle;
                end else begin
                    post_cnt_d = post_cnt_q - CYC_W'(1);
                end
            end
            StGap: begin
                if (accept) begin
                    pend_valid_d = 1'b1;
                    pend_gap_d   = wr_gap_i;
                    pend_len_d   = len_in;
                end
                if (gap_cnt_q == GAP_W'(1)) state_d = StData;
                else gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            StData: begin
                if (len_cnt_q == LEN_W'(1)) begin
                    if (pend_valid_q) begin
                        has_next     = 1'b1;
                        nxt_from     = 1'b1;
                        nxt_gap      = pend_gap_q;
                        nxt_len      = pend_len_q;
                        pend_valid_d = 1'b0;
                    end else if (accept) begin
                        has_next = 1'b1;
                        nxt_from = 1'b1;
                    end else if (post_eff != '0) begin
                        state_d    = StPost;
                        post_cnt_d = post_eff;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    len_cnt_d = len_cnt_q - LEN_W'(1);
                    if (accept) begin
                        pend_valid_d = 1'b1;
                        pend_gap_d   = wr_gap_i;
                        pend_len_d   = len_in;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (has_next) begin
            gap_cnt_d   = nxt_gap;
            gap_tot_d   = nxt_gap;
            from_data_d = nxt_from;
            len_cnt_d   = nxt_len;
            state_d     = (nxt_gap == '0) ? StData : StGap;
        end
    end

    // Outputs are derived from the next state so the registered slot lines up with it.
    always_comb begin
        dqs_bits_d   = '0;
        dqs_oe_d     = 1'b0;
        data_phase_d = 1'b0;
        interamble_d = 1'b0;
        rem          = 32'(gap_cnt_d);
        elapsed      = 32'(gap_tot_d) - rem;
        case (state_d)
            StGap: begin
                if (rem <= 32'(pre_eff)) begin
                    dqs_bits_d = amble_slot(cfg_pre_pattern_i, rem);
                    dqs_oe_d   = 1'b1;
                end else if (from_data_d && (elapsed < 32'(post_eff))) begin
                    dqs_bits_d = amble_slot(cfg_post_pattern_i, 32'(post_eff) - elapsed);
                    dqs_oe_d   = 1'b1;
                end
                interamble_d = from_data_d &&
                               (32'(gap_tot_d) < (32'(pre_eff) + 32'(post_eff)));
            end
            StData: begin
                dqs_bits_d   = DATA_PAT;
                dqs_oe_d     = 1'b1;
                data_phase_d = 1'b1;
            end
            StPost: begin
                dqs_bits_d = amble_slot(cfg_post_pattern_i, 32'(post_cnt_d));
                dqs_oe_d   = 1'b1;
            end
            default: ;
        endcase
        busy_d     = (state_d != StIdle) || pend_valid_d;
        wr_ready_d = (state_d == StIdle) || (state_d == StPost) || !pend_valid_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            gap_cnt_q    <= '0;
            gap_tot_q    <= '0;
            from_data_q  <= 1'b0;
            len_cnt_q    <= '0;
            post_cnt_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_gap_q   <= '0;
            pend_len_q   <= '0;
            dqs_bits_o   <= '0;
            dqs_oe_o     <= 1'b0;
            data_phase_o <= 1'b0;
            interamble_o <= 1'b0;
            busy_o       <= 1'b0;
            wr_ready_o   <= 1'b1;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            gap_tot_q    <= gap_tot_d;
            from_data_q  <= from_data_d;
            len_cnt_q    <= len_cnt_d;
            post_cnt_q   <= post_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_gap_q   <= pend_gap_d;
            pend_len_q   <= pend_len_d;
            dqs_bits_o   <= dqs_bits_d;
            dqs_oe_o     <= dqs_oe_d;
            data_phase_o <= data_phase_d;
            interamble_o <= interamble_d;
            busy_o       <= busy_d;
            wr_ready_o   <= wr_ready_d;
        end
    end

`ifdef WR_AMBLE_STATS_EN
    logic inter_evt, seam_evt;

    // Only a DATA->GAP transition can start an interamble; DATA->DATA is a gap-0 chain.
    assign inter_evt = (state_q == StData) && (state_d == StGap) && interamble_d;
    assign seam_evt  = (state_q == StData) && (state_d == StData) && (len_cnt_q == LEN_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_inter_cnt_o    <= '0;
            stat_seamless_cnt_o <= '0;
        end else begin
            if (inter_evt && (stat_inter_cnt_o != 16'hFFFF)) begin
                stat_inter_cnt_o <= stat_inter_cnt_o + 16'd1;
            end
            if (seam_evt && (stat_seamless_cnt_o != 16'hFFFF)) begin
                stat_seamless_cnt_o <= stat_seamless_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/write_amble_gen.md
Name: write_amble_gen

Overview:
Parametrised next-generation write strobe amble generator for the DDR5 PHY write path. Accepts write-burst requests from the write scheduler and drives per-cycle SER_W-bit DQS serializer slices. Each burst gets a programmable preamble, a toggling data phase and a programmable postamble. When the gap between bursts is too short for a full postamble plus preamble, it merges them into an interamble. Sits between the write scheduler and the DQS serializer.

Parameters:
SER_W, 2, strobe bits emitted per clock (serialization ratio, even, >=2)
PAT_W, 8, preamble/postamble pattern width; multiple of SER_W
CYC_W, 3, width of amble length fields; must hold PAT_W/SER_W
GAP_W, 4, width of requested gap in cycles
LEN_W, 4, width of data-phase length in cycles

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
cfg_pre_pattern_i  in  PAT_W  preamble pattern; low pre_cyc*SER_W bits used, MSB-first
cfg_pre_cyc_i  in  CYC_W  preamble length in cycles (0 = none; >PAT_W/SER_W clamps to max)
cfg_post_pattern_i  in  PAT_W  postamble pattern; low post_cyc*SER_W bits used, MSB-first
cfg_post_cyc_i  in  CYC_W  postamble length in cycles, same clamp rule
wr_valid_i  in  1  burst request
wr_ready_o  out  1  request accepted when wr_valid_i & wr_ready_o
wr_gap_i  in  GAP_W  cycles between previous data end (or acceptance if idle) and data start
wr_len_i  in  LEN_W  data-phase length in cycles (0 treated as 1)
dqs_bits_o  out  SER_W  strobe slice for this cycle
dqs_oe_o  out  1  strobe drive enable
data_phase_o  out  1  DQ data slot active
interamble_o  out  1  current slot belongs to a merged interamble
busy_o  out  1  FSM not IDLE or request pending

Behaviour:
- All outputs registered. Reset values: dqs_bits_o=0, dqs_oe_o=0, data_phase_o=0, interamble_o=0, busy_o=0, wr_ready_o=1. Reset mid-operation drops the active burst and the pending request; next cycle is IDLE.
- cfg_* are quasi-static and may change only while busy_o=0; changes while busy_o=1 give unspecified output.
- FSM states: IDLE, GAP, DATA, POST. One-deep pending register.
- IDLE, request accepted at cycle T: first slot at T+1. gap g>0 -> GAP for g cycles, DATA at T+1+g. g=0 -> DATA at T+1.
- GAP: r = remaining gap cycles including the current one (g..1).
  - r<=pre_cyc: preamble slot cfg_pre_pattern_i[r*SER_W-1 -: SER_W], oe=1. Short gaps therefore truncate the preamble from its high end.
  - Else, if GAP was entered from DATA and e=g-r < post_cyc: postamble slot cfg_post_pattern_i[(post_cyc-e)*SER_W-1 -: SER_W], oe=1.
  - Else: bits=0, oe=0.
  - Preamble has priority over postamble.
  - interamble_o=1 on every GAP slot when entered from DATA and g < pre_cyc+post_cyc.
- DATA: lasts wr_len_i cycles. dqs_bits_o = alternating pattern, MSB=1 (2'b10 for SER_W=2). oe=1, data_phase_o=1.
- Last DATA cycle:
  - pending valid -> consume it. If its gap >0, go to GAP (from-DATA). If its gap =0, the next DATA starts next cycle, seamless with no amble.
  - Otherwise -> POST.
- POST: post_cyc cycles of postamble slots, then IDLE. post_cyc=0 goes straight to IDLE. A request accepted in POST aborts the postamble and is handled as from IDLE (no postamble owed).
- wr_ready_o: 1 in IDLE/POST; in GAP/DATA equals !pending_valid. Acceptance in the last DATA cycle is valid and is consumed at that boundary.
- Gap and length counters are GAP_W/LEN_W wide, decrement only, no wrap.

Optional Feature:
WR_AMBLE_STATS_EN: adds stat_inter_cnt_o (16-bit out) and stat_seamless_cnt_o (16-bit out).
- stat_inter_cnt_o counts interamble events, one per GAP entry with interamble_o.
- stat_seamless_cnt_o counts gap=0 back-to-back bursts.
- Both saturate at 16'hFFFF and reset to 0.
Without the macro, neither port nor counter exists.

Test Plan:
1. Common setup for all scenarios: SER_W=2, pre=8'hB4/pre_cyc=2, post=8'h02/post_cyc=1.
2. Idle request gap=3 len=4 accepted at T -> T+1 oe=0, T+2 01, T+3 00, T+4..T+7 10 with data_phase_o=1, T+8 10 postamble, T+9 IDLE, busy_o=0.
3. Second request gap=0 len=4 accepted during first DATA -> 8 consecutive data cycles, no amble, wr_ready_o=0 while pending.
4. Pending gap=2 after data end D -> D+1 01, D+2 00 (preamble overrides postamble), interamble_o=1 both, DATA at D+3.
5. Pending gap=5 -> D+1 10 (postamble), D+2 oe=0, D+3 01, D+4 00, interamble_o=0.
6. rst_i asserted mid-DATA -> outputs reset values immediately; pending lost; new request after release behaves as scenario 2.
